// File: rtl/math_sched_pkg.sv
// Shared types and helpers for the dot-unit scheduler.
//   vec3_t        : default-width (32-bit) 3-lane Q-format vector, lane 0 in [0]
//   hold_state_e  : issue-side holding register state
//   tag_w()       : width of a requester tag for a given requester count
package math_sched_pkg;

  localparam int VEC_D_BITS = 32;

  typedef logic signed [2:0][VEC_D_BITS-1:0] vec3_t;

  typedef enum logic {
    HOLD_EMPTY = 1'b0,
    HOLD_FULL  = 1'b1
  } hold_state_e;

  // A single requester still needs one tag bit so the FIFO has a legal width.
  function automatic int tag_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sched_tag_fifo.sv
// Synchronous tag FIFO recording which requester owns each result in flight.
//   clock, reset : single clock, synchronous active-high reset
//   push, push_data : write one tag (ignored when full)
//   pop          : retire the head tag (ignored when empty)
//   head         : first-word-fall-through read data
//   full, empty, count : occupancy status; count is $clog2(DEPTH)+1 bits
module sched_tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dot_share_sched.sv
// Shares one FIFO-in/FIFO-out dot unit among N_REQ requesters.
//   clock, reset          : single clock, synchronous active-high reset
//   req_empty/req_rd_en   : requester FWFT FIFOs; req_rd_en is one-hot or zero
//   req_x, req_y          : per-requester operand vectors, valid while !req_empty
//   unit_x, unit_y        : holding register presented to the dot unit
//   unit_in_empty/_rd_en  : holding register status / consume strobe from the unit
//   unit_out/_empty/_rd_en: dot unit result FIFO head / empty / pop
//   res_dout, res_wr_en   : result data (shared) and one-hot consumer write strobe
//   res_full              : consumer FIFO full flags
//   busy                  : holding register valid or results still in flight
//   err_orphan            : sticky, unit produced a result with no tag pending
//   hold_state            : current holding-register state, for observation
//
// Handshakes: every FIFO interface is empty/rd_en (or full/wr_en). A transfer
// happens on a rising edge exactly when the strobe is high and the opposite
// flag is low in that cycle; strobes are combinational and are never raised
// against an empty source or a full sink.
module dot_share_sched
  import math_sched_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int D_BITS    = 32,
  parameter int TAG_DEPTH = 16
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [N_REQ-1:0]                     req_empty,
  output logic [N_REQ-1:0]                     req_rd_en,
  input  logic [N_REQ-1:0][2:0][D_BITS-1:0]    req_x,
  input  logic [N_REQ-1:0][2:0][D_BITS-1:0]    req_y,
  output logic [2:0][D_BITS-1:0]               unit_x,
  output logic [2:0][D_BITS-1:0]               unit_y,
  output logic                                 unit_in_empty,
  input  logic                                 unit_in_rd_en,
  input  logic [D_BITS-1:0]                    unit_out,
  input  logic                                 unit_out_empty,
  output logic                                 unit_out_rd_en,
  output logic [D_BITS-1:0]                    res_dout,
  output logic [N_REQ-1:0]                     res_wr_en,
  input  logic [N_REQ-1:0]                     res_full,
  output logic                                 busy,
  output logic                                 err_orphan,
  output hold_state_e                          hold_state
);

  localparam int TAG_W = tag_w(N_REQ);
  localparam int CNT_W = $clog2(TAG_DEPTH) + 1;

  logic [TAG_W-1:0] rr_ptr;
  logic [TAG_W-1:0] winner;
  logic [TAG_W-1:0] tag_head;
  logic [CNT_W-1:0] tag_count;
  logic             tag_full;
  logic             tag_empty;
  logic             hold_valid;
  logic             grant;
  logic             ret;

  // First pending requester after ptr, wrapping; the nearest candidate is
  // evaluated last so it wins.
  function automatic logic [TAG_W-1:0] rr_pick(input logic [N_REQ-1:0] pend,
                                               input logic [TAG_W-1:0] ptr);
    logic [TAG_W-1:0] pick;
    int idx;
    pick = ptr;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (pend[idx]) pick = TAG_W'(idx);
    end
    return pick;
  endfunction

  assign hold_valid = (hold_state == HOLD_FULL);
  assign winner     = rr_pick(~req_empty, rr_ptr);

  // A grant may refill the holding register in the same cycle it is consumed.
  assign grant = !reset && (!hold_valid || unit_in_rd_en) && !tag_full && (|(~req_empty));

  // Return path is strictly in issue order: a full consumer stalls everything.
  assign ret = !reset && !unit_out_empty && !tag_empty && !res_full[tag_head];

  assign req_rd_en      = grant ? (N_REQ'(1) << winner) : '0;
  assign unit_out_rd_en = ret;
  assign res_wr_en      = ret ? (N_REQ'(1) << tag_head) : '0;
  assign res_dout       = unit_out;
  assign unit_in_empty  = reset || !hold_valid;
  assign busy           = hold_valid || (tag_count != '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      hold_state <= HOLD_EMPTY;
      unit_x     <= '0;
      unit_y     <= '0;
      rr_ptr     <= TAG_W'(N_REQ - 1);
      err_orphan <= 1'b0;
    end else begin
      case (hold_state)
        HOLD_EMPTY: begin
          if (grant) hold_state <= HOLD_FULL;
        end
        HOLD_FULL: begin
          if (!grant && unit_in_rd_en) hold_state <= HOLD_EMPTY;
        end
        default: hold_state <= HOLD_EMPTY;
      endcase
      if (grant) begin
        unit_x <= req_x[winner];
        unit_y <= req_y[winner];
        rr_ptr <= winner;
      end
      if (!unit_out_empty && tag_empty) err_orphan <= 1'b1;
    end
  end

  sched_tag_fifo #(
    .WIDTH (TAG_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (grant),
    .push_data (winner),
    .pop       (ret),
    .head      (tag_head),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (tag_count)
  );

endmodule

// File: tb/tb_dot_share_sched.sv
module tb_dot_share_sched;
  import math_sched_pkg::*;

  localparam int N   = 4;
  localparam int D   = 32;
  localparam int TD  = 16;
  localparam int LAT = 3;

  typedef struct packed {
    logic [2:0][D-1:0] x;
    logic [2:0][D-1:0] y;
  } op_t;

  // clock / reset
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [N-1:0]              req_empty;
  logic [N-1:0]              req_rd_en;
  logic [N-1:0][2:0][D-1:0]  req_x;
  logic [N-1:0][2:0][D-1:0]  req_y;
  logic [2:0][D-1:0]         unit_x;
  logic [2:0][D-1:0]         unit_y;
  logic                      unit_in_empty;
  logic                      unit_in_rd_en;
  logic [D-1:0]              unit_out;
  logic                      unit_out_empty;
  logic                      unit_out_rd_en;
  logic [D-1:0]              res_dout;
  logic [N-1:0]              res_wr_en;
  logic [N-1:0]              res_full;
  logic                      busy;
  logic                      err_orphan;
  hold_state_e               hold_state;

  dot_share_sched #(.N_REQ(N), .D_BITS(D), .TAG_DEPTH(TD)) dut (
    .clock          (clock),
    .reset          (reset),
    .req_empty      (req_empty),
    .req_rd_en      (req_rd_en),
    .req_x          (req_x),
    .req_y          (req_y),
    .unit_x         (unit_x),
    .unit_y         (unit_y),
    .unit_in_empty  (unit_in_empty),
    .unit_in_rd_en  (unit_in_rd_en),
    .unit_out       (unit_out),
    .unit_out_empty (unit_out_empty),
    .unit_out_rd_en (unit_out_rd_en),
    .res_dout       (res_dout),
    .res_wr_en      (res_wr_en),
    .res_full       (res_full),
    .busy           (busy),
    .err_orphan     (err_orphan),
    .hold_state     (hold_state)
  );

  // environment state: requester FIFOs and the dot unit load
  op_t        req_q[N][$];
  logic [D-1:0] dot_data_q[$];
  int         dot_time_q[$];

  // reference model
  logic [D-1:0] exp_q[N][$];
  int         owner_q[$];
  logic       m_hold;
  logic [2:0][D-1:0] m_hx;
  logic [2:0][D-1:0] m_hy;
  int         m_rr;
  logic       m_orphan;

  // knobs
  int         cyc;
  logic       uin_rd_knob;
  logic [N-1:0] full_mask;
  logic       force_orphan;
  logic       rand_mode;

  // observations of the DUT
  int         obs_wr_cnt[N];
  int         uord_cnt;
  int         grant_log[$];
  int         ret_log[$];
  logic [D-1:0] last_dout;
  logic [N-1:0] last_rd;
  logic [N-1:0] last_wr;
  logic       last_uie;
  logic       last_busy;
  logic       last_orphan;

  int n_pass;
  int n_total;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Q16 three-lane dot product of the load: exact sum, then rescale.
  function automatic logic [D-1:0] dot3(input logic [2:0][D-1:0] x, input logic [2:0][D-1:0] y);
    longint acc;
    acc = 0;
    for (int l = 0; l < 3; l++) acc += longint'($signed(x[l])) * longint'($signed(y[l]));
    acc = acc >>> 16;
    return acc[D-1:0];
  endfunction

  task automatic drive_inputs();
    logic rdy;
    for (int i = 0; i < N; i++) begin
      req_empty[i] = (req_q[i].size() == 0);
      if (req_q[i].size() > 0) begin
        req_x[i] = req_q[i][0].x;
        req_y[i] = req_q[i][0].y;
      end else begin
        req_x[i] = '0;
        req_y[i] = '0;
      end
    end
    if (rand_mode) begin
      unit_in_rd_en = 1'($urandom_range(0, 1));
      res_full = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 15)) : '0;
    end else begin
      unit_in_rd_en = uin_rd_knob;
      res_full = full_mask;
    end
    rdy = (dot_time_q.size() > 0) && (dot_time_q[0] <= cyc);
    unit_out       = rdy ? dot_data_q[0] : (force_orphan ? 32'hDEAD_BEEF : '0);
    unit_out_empty = !(rdy || force_orphan);
  endtask

  // One clock: check at the falling edge, advance model, drive after the rising edge.
  task automatic step();
    logic [N-1:0] e_rd;
    logic [N-1:0] e_wr;
    logic e_uord;
    logic dot_rdy;
    logic any;
    logic set_orphan;
    int g;
    int t;
    op_t op;
    @(negedge clock);
    dot_rdy = !unit_out_empty;
    e_rd = '0;
    e_wr = '0;
    e_uord = 1'b0;
    g = -1;
    if (!reset) begin
      any = 1'b0;
      for (int i = 0; i < N; i++) if (req_q[i].size() > 0) any = 1'b1;
      if ((!m_hold || unit_in_rd_en) && owner_q.size() < TD && any) begin
        for (int k = 1; k <= N; k++) begin
          if (g < 0 && req_q[(m_rr + k) % N].size() > 0) g = (m_rr + k) % N;
        end
        e_rd[g] = 1'b1;
      end
      if (dot_rdy && owner_q.size() > 0 && !res_full[owner_q[0]]) begin
        e_uord = 1'b1;
        e_wr[owner_q[0]] = 1'b1;
      end
    end
    chk("req_rd_en", req_rd_en, e_rd);
    chk("res_wr_en", res_wr_en, e_wr);
    chk("unit_out_rd_en", unit_out_rd_en, e_uord);
    chk("unit_in_empty", unit_in_empty, reset ? 1'b1 : !m_hold);
    chk("busy", busy, m_hold || owner_q.size() > 0);
    chk("err_orphan", err_orphan, m_orphan);
    chk("hold_state", hold_state, m_hold ? HOLD_FULL : HOLD_EMPTY);
    chk("res_dout_pass", res_dout, unit_out);

    // record observations
    last_rd = req_rd_en; last_wr = res_wr_en; last_uie = unit_in_empty;
    last_busy = busy; last_orphan = err_orphan;
    for (int i = 0; i < N; i++) begin
      if (req_rd_en[i]) grant_log.push_back(i);
      if (res_wr_en[i]) begin
        obs_wr_cnt[i]++;
        ret_log.push_back(i);
        last_dout = res_dout;
      end
    end
    if (unit_out_rd_en) uord_cnt++;

    // dot unit load: consume holding register, pop result FIFO
    if (!reset && unit_in_rd_en && m_hold) chk("unit_x", unit_x, m_hx);
    if (!reset && unit_in_rd_en && m_hold) chk("unit_y", unit_y, m_hy);
    if (unit_out_rd_en && dot_time_q.size() > 0 && dot_time_q[0] <= cyc) begin
      void'(dot_data_q.pop_front());
      void'(dot_time_q.pop_front());
    end
    if (!reset && unit_in_rd_en && !unit_in_empty) begin
      dot_data_q.push_back(dot3(unit_x, unit_y));
      dot_time_q.push_back(cyc + LAT);
    end

    // model update
    if (reset) begin
      m_hold = 1'b0;
      m_rr = N - 1;
      owner_q.delete();
      m_orphan = 1'b0;
      for (int i = 0; i < N; i++) exp_q[i].delete();
    end else begin
      set_orphan = dot_rdy && owner_q.size() == 0;
      if (e_uord) begin
        t = owner_q.pop_front();
        if (exp_q[t].size() > 0) chk("result", res_dout, exp_q[t].pop_front());
        else chk("result_extra", 1'b1, 1'b0);
      end
      if (g >= 0) begin
        op = req_q[g].pop_front();
        m_hx = op.x;
        m_hy = op.y;
        m_hold = 1'b1;
        owner_q.push_back(g);
        exp_q[g].push_back(dot3(op.x, op.y));
        m_rr = g;
      end else if (unit_in_rd_en) begin
        m_hold = 1'b0;
      end
      if (set_orphan) m_orphan = 1'b1;
    end
    cyc++;
    @(posedge clock);
    #1;
    drive_inputs();
  endtask

  task automatic clear_obs();
    for (int i = 0; i < N; i++) obs_wr_cnt[i] = 0;
    uord_cnt = 0;
    grant_log.delete();
    ret_log.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    dot_data_q.delete();
    dot_time_q.delete();
    for (int i = 0; i < N; i++) req_q[i].delete();
    drive_inputs();
    step();
    step();
    reset = 1'b0;
    clear_obs();
    drive_inputs();
  endtask

  task automatic run_until_idle(input int max_cyc);
    int n;
    logic idle;
    n = 0;
    idle = 1'b0;
    while (!idle && n < max_cyc) begin
      step();
      n++;
      idle = !m_hold && owner_q.size() == 0 && dot_data_q.size() == 0;
      for (int i = 0; i < N; i++) if (req_q[i].size() > 0) idle = 1'b0;
    end
    chk("drain_timeout", idle, 1'b1);
  endtask

  task automatic push_rand(input int r);
    op_t op;
    for (int l = 0; l < 3; l++) begin
      op.x[l] = $urandom;
      op.y[l] = $urandom;
    end
    req_q[r].push_back(op);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    op_t op;
    n_pass = 0; n_total = 0; cyc = 0;
    m_hold = 1'b0; m_rr = N - 1; m_orphan = 1'b0; m_hx = '0; m_hy = '0;
    uin_rd_knob = 1'b1; full_mask = '0; force_orphan = 1'b0; rand_mode = 1'b0;
    last_dout = '0;
    clear_obs();
    reset = 1'b1;
    drive_inputs();

    // reset state
    do_reset();
    step();
    chk("rst_hold_state", hold_state, HOLD_EMPTY);
    chk("rst_unit_x", unit_x, 96'h0);
    chk("rst_busy", last_busy, 1'b0);

    // single request from requester 2: (1,2,3).(4,5,6) in Q16
    op.x[0] = 32'h0001_0000; op.x[1] = 32'h0002_0000; op.x[2] = 32'h0003_0000;
    op.y[0] = 32'h0004_0000; op.y[1] = 32'h0005_0000; op.y[2] = 32'h0006_0000;
    req_q[2].push_back(op);
    drive_inputs();
    run_until_idle(50);
    chk("single_wr_cnt", {8'(obs_wr_cnt[3]), 8'(obs_wr_cnt[2]), 8'(obs_wr_cnt[1]), 8'(obs_wr_cnt[0])},
        32'h0001_0000);
    chk("single_dout", last_dout, 32'h0020_0000);
    chk("single_strobe", ret_log.size() == 1 ? ret_log[0] : -1, 2);

    // all four always pending: round-robin 0,1,2,3,...
    do_reset();
    for (int r = 0; r < N; r++) for (int k = 0; k < 4; k++) push_rand(r);
    drive_inputs();
    run_until_idle(100);
    chk("rr_count", grant_log.size(), 16);
    for (int i = 0; i < 16 && i < grant_log.size(); i++) chk("rr_order", grant_log[i], i % N);
    for (int i = 0; i < N; i++) chk("rr_per_consumer", obs_wr_cnt[i], 4);

    // head-of-line blocking on consumer 1
    do_reset();
    full_mask = 4'b0010;
    push_rand(1);
    push_rand(2);
    drive_inputs();
    repeat (20) step();
    chk("hol_no_wr", ret_log.size(), 0);
    chk("hol_no_pop", uord_cnt, 0);
    full_mask = '0;
    drive_inputs();
    run_until_idle(50);
    chk("hol_count", ret_log.size(), 2);
    if (ret_log.size() == 2) begin
      chk("hol_first", ret_log[0], 1);
      chk("hol_second", ret_log[1], 2);
    end

    // tag FIFO full: 17th grant withheld until a result drains
    do_reset();
    full_mask = 4'hF;
    for (int k = 0; k < 17; k++) push_rand(0);
    drive_inputs();
    repeat (25) step();
    chk("tagfull_grants", grant_log.size(), 16);
    chk("tagfull_rd_en", last_rd, 4'b0000);
    chk("tagfull_busy", last_busy, 1'b1);
    full_mask = 4'b1110;
    drive_inputs();
    step();
    chk("tagfull_drain_no_grant", grant_log.size(), 16);
    step();
    chk("tagfull_resume", grant_log.size(), 17);
    run_until_idle(100);
    full_mask = '0;

    // orphan result
    do_reset();
    force_orphan = 1'b1;
    drive_inputs();
    step();
    force_orphan = 1'b0;
    drive_inputs();
    repeat (5) step();
    chk("orphan_sticky", last_orphan, 1'b1);
    do_reset();
    step();
    chk("orphan_cleared", last_orphan, 1'b0);

    // reset while holding data with three tags queued
    full_mask = 4'hF;
    uin_rd_knob = 1'b1;
    for (int k = 0; k < 3; k++) push_rand(1);
    drive_inputs();
    repeat (3) step();
    uin_rd_knob = 1'b0;
    drive_inputs();
    step();
    chk("pre_rst_uie", last_uie, 1'b0);
    chk("pre_rst_busy", last_busy, 1'b1);
    reset = 1'b1;
    dot_data_q.delete();
    dot_time_q.delete();
    for (int i = 0; i < N; i++) req_q[i].delete();
    drive_inputs();
    step();
    reset = 1'b0;
    full_mask = '0;
    uin_rd_knob = 1'b1;
    drive_inputs();
    step();
    chk("post_rst_uie", last_uie, 1'b1);
    chk("post_rst_busy", last_busy, 1'b0);
    chk("post_rst_strobes", {last_rd, last_wr}, 8'h00);
    clear_obs();
    for (int r = 0; r < N; r++) push_rand(r);
    drive_inputs();
    run_until_idle(50);
    chk("post_rst_first_grant", grant_log.size() > 0 ? grant_log[0] : -1, 0);

    // randomized traffic against the model
    do_reset();
    rand_mode = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) != 0) begin
        int r;
        r = $urandom_range(0, N - 1);
        if (req_q[r].size() < 4) push_rand(r);
      end
      drive_inputs();
      step();
    end
    rand_mode = 1'b0;
    full_mask = '0;
    uin_rd_knob = 1'b1;
    drive_inputs();
    run_until_idle(300);
    for (int i = 0; i < N; i++) chk("rand_all_delivered", exp_q[i].size(), 0);
    chk("rand_no_orphan", last_orphan, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
